soc_arbiter_bb: RTL and testbench

Multi-master arbiter for the Blackbone bus: funnels `MASTERS` initiator ports onto one Blackbone target port. It is the upstream complement of the address decoder. A CPU/DMA cluster feeds this block, and its single output drives the decoder's master side. Arbitration is registered and round-robin, with grant hold for back-to-back beats, optional burst limiting, and per-master read-valid return.

---
 rtl/soc_bb_pkg.sv | 16 +
 rtl/soc_arbiter_rr.sv | 32 +++
 rtl/soc_arbiter_bb.sv | 142 ++++++++++++++
 tb/tb_soc_arbiter_bb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bb_pkg.sv
// Shared Blackbone arbiter types: FSM state encoding, master-count ceiling
// and the round-robin pointer wrap helper.
package soc_bb_pkg;

  localparam int BB_MAX_MASTERS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } bb_arb_state_t;

  function automatic int bb_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/soc_arbiter_rr.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr_i, wrapping modulo N, plus an any-request flag.
module soc_arbiter_rr #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam int CW = IW + 1;

  logic [CW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + CW'(k);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (req_i[cand[IW-1:0]]) begin
        idx_o = cand[IW-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_arbiter_bb.sv
// Blackbone multi-master arbiter: registered round-robin ownership with grant
// hold; burst limiting is built only when SOC_ARBITER_BB_BURST_LIMIT_EN is defined.
module soc_arbiter_bb
  import soc_bb_pkg::*;
#(
  parameter int MASTERS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [MASTERS-1:0][DATA_WIDTH-1:0]   m_din_i,
  input  logic [MASTERS-1:0]                   m_en_i,
  input  logic [MASTERS-1:0]                   m_we_i,
  output logic [MASTERS-1:0]                   m_gnt_o,
  output logic [MASTERS-1:0]                   m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                m_dout_o,
  output logic [ADDR_WIDTH-1:0]                s_addr_o,
  output logic [DATA_WIDTH-1:0]                s_din_o,
  output logic                                 s_en_o,
  output logic                                 s_we_o,
  input  logic [DATA_WIDTH-1:0]                s_dout_i,
  output bb_arb_state_t                        dbg_state_o
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  bb_arb_state_t state_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] rd_id_q;
  logic          rd_pend_q;

  logic [IW-1:0] pick_ptr;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] next_ptr;
  logic          pick_any;
  logic          own_active;
  logic          owner_req;
  logic          force_out;
  logic          beat;
  logic          leave;

  assign own_active  = (state_q == OWN);
  assign owner_req   = m_en_i[owner_q];
  assign next_ptr    = IW'(bb_wrap_inc(int'(owner_q), MASTERS));
  assign dbg_state_o = state_q;

`ifdef SOC_ARBITER_BB_BURST_LIMIT_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [BW-1:0] beats_q;
  logic          others_req;
  logic          new_owner;

  assign others_req = |(m_en_i & ~(MASTERS'(1) << owner_q));
  assign force_out  = own_active && owner_req && (beats_q == BW'(MAX_BURST)) && others_req;
  assign new_owner  = pick_any && (!own_active || leave);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beats_q <= '0;
    end else if (new_owner) begin
      beats_q <= '0;
    end else if (beat && (beats_q != BW'(MAX_BURST))) begin
      beats_q <= beats_q + 1'b1;
    end
  end
`else
  assign force_out = 1'b0;
`endif

  // Handshake: a beat is accepted exactly when m_gnt_o[i] is high; a master
  // holds m_en_i and its address/data/we stable until it sees that grant.
  // A leaving owner uses its drop cycle to pick the successor, so handover
  // costs exactly one dead cycle.
  assign beat     = own_active && owner_req && !force_out;
  assign leave    = own_active && !beat;
  assign pick_ptr = own_active ? next_ptr : ptr_q;

  soc_arbiter_rr #(
    .N  (MASTERS),
    .IW (IW)
  ) u_rr (
    .req_i (m_en_i),
    .ptr_i (pick_ptr),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_dout_o   = '0;
    s_addr_o   = '0;
    s_din_o    = '0;
    s_we_o     = 1'b0;
    s_en_o     = beat;
    if (own_active) begin
      s_addr_o = m_addr_i[owner_q];
      s_din_o  = m_din_i[owner_q];
      s_we_o   = m_we_i[owner_q];
    end
    if (beat) m_gnt_o[owner_q] = 1'b1;
    if (rd_pend_q) begin
      m_rvalid_o[rd_id_q] = 1'b1;
      m_dout_o            = s_dout_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      rd_pend_q <= beat && !m_we_i[owner_q];
      if (beat && !m_we_i[owner_q]) rd_id_q <= owner_q;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q <= OWN;
            owner_q <= pick_idx;
          end
        end
        OWN: begin
          if (leave) begin
            ptr_q <= next_ptr;
            if (pick_any) owner_q <= pick_idx;
            else          state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_arbiter_bb.sv
// Bench for soc_arbiter_bb (3 masters): per-cycle vector tables plus
// hand-written reset sequences, with a read-data scoreboard queue.
module tb_soc_arbiter_bb;
  import soc_bb_pkg::*;

  localparam int M  = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic                clk = 1'b0;
  logic                rst_ni = 1'b0;
  logic [M-1:0][AW-1:0] m_addr;
  logic [M-1:0][DW-1:0] m_din;
  logic [M-1:0]        m_en = '0;
  logic [M-1:0]        m_we = '0;
  logic [M-1:0]        m_gnt;
  logic [M-1:0]        m_rvalid;
  logic [DW-1:0]       m_dout;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_din;
  logic                s_en;
  logic                s_we;
  logic [DW-1:0]       s_dout = '0;
  bb_arb_state_t       dbg_state;

  always #5 clk = ~clk;

  soc_arbiter_bb #(
    .MASTERS    (M),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_BURST  (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .m_addr_i    (m_addr),
    .m_din_i     (m_din),
    .m_en_i      (m_en),
    .m_we_i      (m_we),
    .m_gnt_o     (m_gnt),
    .m_rvalid_o  (m_rvalid),
    .m_dout_o    (m_dout),
    .s_addr_o    (s_addr),
    .s_din_o     (s_din),
    .s_en_o      (s_en),
    .s_we_o      (s_we),
    .s_dout_i    (s_dout),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    logic [2:0]  en;
    logic [2:0]  we;
    logic [31:0] dout;
    logic [2:0]  gnt;
    logic [2:0]  rv;
  } vec_t;

  vec_t        vq[$];
  logic [33:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    oh2idx = 2'd0;
    for (int i = 0; i < 3; i++) if (oh[i]) oh2idx = 2'(i);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [2:0] en, input logic [2:0] we, input logic [2:0] gnt,
                     input logic [2:0] rv, input logic [31:0] dout);
    vec_t v;
    v.en = en; v.we = we; v.gnt = gnt; v.rv = rv; v.dout = dout;
    vq.push_back(v);
  endtask

  task automatic check_row(input vec_t v, input logic [31:0] nxt);
    logic [33:0] e;
    cmp("gnt", 32'(m_gnt), 32'(v.gnt));
    cmp("rvalid", 32'(m_rvalid), 32'(v.rv));
    cmp("s_en", 32'(s_en), 32'(|v.gnt));
    if (v.gnt != 3'b000) begin
      cmp("s_addr", s_addr, m_addr[oh2idx(v.gnt)]);
      cmp("s_din", s_din, m_din[oh2idx(v.gnt)]);
      cmp("s_we", 32'(s_we), 32'(|(v.we & v.gnt)));
    end
    if (v.rv == 3'b000) cmp("dout_idle", m_dout, 32'h0);
    if (m_rvalid != 3'b000) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_sb: rvalid %b with nothing expected at %0t", m_rvalid, $time);
      end else begin
        e = exp_q.pop_front();
        cmp("rd_id", 32'(oh2idx(m_rvalid)), 32'(e[33:32]));
        cmp("rd_data", m_dout, e[31:0]);
      end
    end
    if (v.gnt != 3'b000 && (v.we & v.gnt) == 3'b000) exp_q.push_back({oh2idx(v.gnt), nxt});
  endtask

  task automatic run_rows();
    for (int i = 0; i < vq.size(); i++) begin
      m_en   = vq[i].en;
      m_we   = vq[i].we;
      s_dout = vq[i].dout;
      #4;
      check_row(vq[i], (i + 1 < vq.size()) ? vq[i+1].dout : 32'h0);
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    m_en   = '0;
    m_we   = '0;
    s_dout = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    cmp({tag, "_gnt"}, 32'(m_gnt), 32'h0);
    cmp({tag, "_rvalid"}, 32'(m_rvalid), 32'h0);
    cmp({tag, "_dout"}, m_dout, 32'h0);
    cmp({tag, "_s_en"}, 32'(s_en), 32'h0);
    cmp({tag, "_s_we"}, 32'(s_we), 32'h0);
    cmp({tag, "_s_addr"}, s_addr, 32'h0);
    cmp({tag, "_s_din"}, s_din, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < M; i++) begin
      m_addr[i] = 32'h100 + 32'h104 * i;
      m_din[i]  = $urandom();
    end

    do_reset();
    s_dout = 32'hCAFE_F00D;
    #2;
    check_all_zero("rst");

    // Single read by M0: grant at cycle 1, data at cycle 2.
    add(3'b001, 3'b000, 3'b000, 3'b000, $urandom());
    add(3'b001, 3'b000, 3'b001, 3'b000, $urandom());
    add(3'b000, 3'b000, 3'b000, 3'b001, 32'hDEAD_BEEF);
    add(3'b000, 3'b000, 3'b000, 3'b000, $urandom());
    run_rows();

    // Simultaneous requests, handover dead cycle, then round-robin M2, M0, M1.
    do_reset();
    add(3'b011, 3'b000, 3'b000, 3'b000, $urandom());
    add(3'b011, 3'b000, 3'b001, 3'b000, $urandom());
    add(3'b011, 3'b001, 3'b001, 3'b001, $urandom());
    add(3'b010, 3'b000, 3'b000, 3'b000, $urandom());
    add(3'b010, 3'b000, 3'b010, 3'b000, $urandom());
    add(3'b000, 3'b000, 3'b000, 3'b010, $urandom());
    add(3'b111, 3'b000, 3'b000, 3'b000, $urandom());
    add(3'b111, 3'b000, 3'b100, 3'b000, $urandom());
    add(3'b011, 3'b000, 3'b000, 3'b100, $urandom());
    add(3'b011, 3'b000, 3'b001, 3'b000, $urandom());
    add(3'b010, 3'b000, 3'b000, 3'b001, $urandom());
    add(3'b010, 3'b010, 3'b010, 3'b000, $urandom());
    add(3'b000, 3'b000, 3'b000, 3'b000, $urandom());
    add(3'b000, 3'b000, 3'b000, 3'b000, $urandom());
    run_rows();

    // M0 streams 10 reads while M1 waits.
    do_reset();
`ifdef SOC_ARBITER_BB_BURST_LIMIT_EN
    add(3'b001, 3'b000, 3'b000, 3'b000, $urandom());
    add(3'b011, 3'b000, 3'b001, 3'b000, $urandom());
    for (int i = 0; i < 3; i++) add(3'b011, 3'b000, 3'b001, 3'b001, $urandom());
    add(3'b011, 3'b000, 3'b000, 3'b001, $urandom());
    add(3'b011, 3'b000, 3'b010, 3'b000, $urandom());
    add(3'b001, 3'b000, 3'b000, 3'b010, $urandom());
    add(3'b001, 3'b000, 3'b001, 3'b000, $urandom());
    for (int i = 0; i < 5; i++) add(3'b001, 3'b000, 3'b001, 3'b001, $urandom());
    add(3'b000, 3'b000, 3'b000, 3'b001, $urandom());
    add(3'b000, 3'b000, 3'b000, 3'b000, $urandom());
`else
    add(3'b001, 3'b000, 3'b000, 3'b000, $urandom());
    add(3'b011, 3'b000, 3'b001, 3'b000, $urandom());
    for (int i = 0; i < 9; i++) add(3'b011, 3'b000, 3'b001, 3'b001, $urandom());
    add(3'b010, 3'b000, 3'b000, 3'b001, $urandom());
    add(3'b010, 3'b000, 3'b010, 3'b000, $urandom());
    add(3'b000, 3'b000, 3'b000, 3'b010, $urandom());
    add(3'b000, 3'b000, 3'b000, 3'b000, $urandom());
`endif
    run_rows();

    // Async reset while M1 owns the bus with a read pending; ptr_q is 1 beforehand.
    do_reset();
    add(3'b001, 3'b000, 3'b000, 3'b000, $urandom());
    add(3'b001, 3'b001, 3'b001, 3'b000, $urandom());
    add(3'b010, 3'b000, 3'b000, 3'b000, $urandom());
    add(3'b010, 3'b000, 3'b010, 3'b000, $urandom());
    run_rows();
    m_en   = 3'b010;
    s_dout = 32'h1234_5678;
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    m_en = '0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
    add(3'b011, 3'b000, 3'b000, 3'b000, $urandom());
    add(3'b011, 3'b000, 3'b001, 3'b000, $urandom());
    add(3'b010, 3'b000, 3'b000, 3'b001, $urandom());
    add(3'b010, 3'b000, 3'b010, 3'b000, $urandom());
    add(3'b000, 3'b000, 3'b000, 3'b010, $urandom());
    add(3'b000, 3'b000, 3'b000, 3'b000, $urandom());
    run_rows();

    cmp("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
